// File: rtl/strand_consensus.sv
// strand_consensus: per-position majority vote over N noisy strand reads, one symbol per beat
// Optional CONSENSUS_ERASURE_EN adds sym_erase: erased beats advance position but cast no vote
module strand_consensus #(
  parameter int N_SYM = 10,
  parameter int A = 4,
  parameter int MAX_STRANDS = 16,
  localparam int SYM_W = $clog2(A),
  localparam int CNT_W = $clog2(MAX_STRANDS + 1),
  localparam int POS_W = $clog2(N_SYM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_of_strands,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym_in,
`ifdef CONSENSUS_ERASURE_EN
  input  logic                   sym_erase,
`endif
  output logic                   sym_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_SYM*SYM_W-1:0] consensus,
  output logic [N_SYM-1:0]       reliable,
  output logic                   busy,
  output logic                   err
);
  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, OUT} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] vote [N_SYM][A];
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] scnt, n_lat, best_c;
  logic [SYM_W-1:0] best_s;
  logic ok, beat, cast, wrap, last;
  assign ok = num_of_strands != '0 && num_of_strands <= CNT_W'(MAX_STRANDS);
  assign beat = sym_valid && sym_ready;
`ifdef CONSENSUS_ERASURE_EN
  assign cast = beat && !sym_erase;
`else
  assign cast = beat;
`endif
  assign wrap = pos == POS_W'(N_SYM - 1);
  assign last = wrap && scnt == n_lat - 1'b1;
  assign sym_ready = state == COLLECT;
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
  // strict > keeps the lowest symbol on ties
  always_comb begin
    best_c = vote[pos][0];
    best_s = '0;
    for (int s = 1; s < A; s++)
      if (vote[pos][s] > best_c) begin
        best_c = vote[pos][s];
        best_s = SYM_W'(s);
      end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start && ok ? COLLECT : IDLE;
      COLLECT: state_d = beat && last ? DECIDE : COLLECT;
      DECIDE:  state_d = wrap ? OUT : DECIDE;
      OUT:     state_d = out_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int p = 0; p < N_SYM; p++)
        for (int s = 0; s < A; s++)
          vote[p][s] <= '0;
      pos <= '0;
      scnt <= '0;
      n_lat <= '0;
      consensus <= '0;
      reliable <= '0;
      err <= 1'b0;
    end else begin
      err <= state == IDLE && start && !ok;
      if (state == IDLE && start && ok) begin
        for (int p = 0; p < N_SYM; p++)
          for (int s = 0; s < A; s++)
            vote[p][s] <= '0;
        pos <= '0;
        scnt <= '0;
        n_lat <= num_of_strands;
      end
      if (cast) vote[pos][sym_in] <= vote[pos][sym_in] + 1'b1;
      if (beat) begin
        pos <= wrap ? '0 : pos + 1'b1;
        if (wrap) scnt <= scnt + 1'b1;
      end
      // the final beat leaves pos at 0, so DECIDE sweeps positions 0..N_SYM-1
      if (state == DECIDE) begin
        consensus[pos*SYM_W +: SYM_W] <= best_s;
        reliable[pos] <= {best_c, 1'b0} > {1'b0, n_lat};
        pos <= wrap ? '0 : pos + 1'b1;
      end
    end
endmodule

// File: tb/tb_strand_consensus.sv
// tb_strand_consensus: directed scoreboard bench for strand_consensus
module tb_strand_consensus;
  localparam int N_SYM = 10;
  localparam int A = 4;
  localparam int MAX_STRANDS = 16;
  localparam int SYM_W = 2;
  localparam int CNT_W = 5;
  typedef struct packed {
    logic [N_SYM*SYM_W-1:0] c;
    logic [N_SYM-1:0]       r;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, sym_valid = 0, out_ready = 0;
  logic [CNT_W-1:0] num_of_strands = '0;
  logic [SYM_W-1:0] sym_in = '0;
`ifdef CONSENSUS_ERASURE_EN
  logic sym_erase = 0;
`endif
  logic sym_ready, out_valid, busy, err;
  logic [N_SYM*SYM_W-1:0] consensus;
  logic [N_SYM-1:0] reliable;
  exp_t sbq[$];
  logic [SYM_W-1:0] rd [MAX_STRANDS][N_SYM];
  bit er [MAX_STRANDS][N_SYM];
  int pass_n = 0, total_n = 0;
  strand_consensus dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_of_strands(num_of_strands),
    .sym_valid(sym_valid), .sym_in(sym_in),
`ifdef CONSENSUS_ERASURE_EN
    .sym_erase(sym_erase),
`endif
    .sym_ready(sym_ready), .out_valid(out_valid), .out_ready(out_ready),
    .consensus(consensus), .reliable(reliable), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic exp_t model(input int n);
    exp_t e;
    int cnt [A];
    int bc, bs;
    e = '0;
    for (int p = 0; p < N_SYM; p++) begin
      for (int s = 0; s < A; s++) cnt[s] = 0;
      for (int k = 0; k < n; k++) if (!er[k][p]) cnt[rd[k][p]]++;
      bc = cnt[0];
      bs = 0;
      for (int s = 1; s < A; s++) if (cnt[s] > bc) begin bc = cnt[s]; bs = s; end
      e.c[p*SYM_W +: SYM_W] = SYM_W'(bs);
      e.r[p] = bc * 2 > n;
    end
    return e;
  endfunction
  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++)
      for (int p = 0; p < N_SYM; p++) rd[k][p] = SYM_W'($urandom_range(A - 1));
  endtask
  task automatic send(input int n, input bit lat);
    int cyc;
    sbq.push_back(model(n));
    start = 1;
    num_of_strands = CNT_W'(n);
    tick();
    start = 0;
    chk("busy_collect", busy, 1);
    chk("ready_collect", sym_ready, 1);
    for (int k = 0; k < n; k++)
      for (int p = 0; p < N_SYM; p++) begin
        if ($urandom_range(3) == 0) begin sym_valid = 0; tick(); end
        sym_valid = 1;
        sym_in = rd[k][p];
`ifdef CONSENSUS_ERASURE_EN
        sym_erase = er[k][p];
`endif
        tick();
      end
    sym_valid = 0;
    chk("ready_drop", sym_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 200) begin tick(); cyc++; end
    chk("out_valid", out_valid, 1);
    if (lat) chk("latency", cyc, N_SYM + 1);
  endtask
  task automatic take(input int hold);
    exp_t e;
    e = sbq.pop_front();
    out_ready = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_cons", consensus, e.c);
      chk("hold_rel", reliable, e.r);
    end
    chk("consensus", consensus, e.c);
    chk("reliable", reliable, e.r);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("after_cons", consensus, e.c);
  endtask
  initial begin
    #12;
    chk("rst_cons", consensus, 0);
    chk("rst_rel", reliable, 0);
    chk("rst_ready", sym_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    tick();
    for (int k = 0; k < 3; k++) for (int p = 0; p < N_SYM; p++) rd[k][p] = SYM_W'(p % 4);
    send(3, 1);
    chk("t1_cons", consensus, 32'h4E4E4);
    chk("t1_rel", reliable, 32'h3FF);
    take(0);
    for (int k = 0; k < 3; k++) for (int p = 0; p < N_SYM; p++) rd[k][p] = '0;
    rd[1][4] = 2;
    send(3, 0);
    chk("t2_pos4", consensus[9:8], 0);
    chk("t2_rel4", reliable[4], 1);
    take(0);
    fill_rand(1);
    for (int p = 0; p < N_SYM; p++) rd[1][p] = rd[0][p];
    rd[0][0] = 1;
    rd[1][0] = 3;
    send(2, 0);
    chk("t3_pos0", consensus[1:0], 1);
    chk("t3_rel0", reliable[0], 0);
    chk("t3_rel_rest", reliable[9:1], 32'h1FF);
    take(0);
    start = 1;
    num_of_strands = 0;
    tick();
    chk("t4_err0", err, 1);
    chk("t4_busy0", busy, 0);
    chk("t4_ready0", sym_ready, 0);
    num_of_strands = 17;
    tick();
    chk("t4_err17", err, 1);
    chk("t4_busy17", busy, 0);
    chk("t4_ready17", sym_ready, 0);
    start = 0;
    tick();
    chk("t4_err_clr", err, 0);
    fill_rand(5);
    send(5, 0);
    take(20);
    start = 1;
    num_of_strands = 3;
    tick();
    start = 0;
    sym_valid = 1;
    repeat (5) begin sym_in = SYM_W'($urandom_range(A - 1)); tick(); end
    #2 rst_n = 0;
    #1;
    sym_valid = 0;
    chk("mid_rst_cons", consensus, 0);
    chk("mid_rst_rel", reliable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", sym_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    rst_n = 1;
    tick();
    fill_rand(4);
    send(4, 1);
    take(0);
    fill_rand(1);
    send(1, 1);
    take(0);
    fill_rand(MAX_STRANDS);
    send(MAX_STRANDS, 1);
    take(3);
    fill_rand(7);
    send(7, 0);
    take(1);
`ifdef CONSENSUS_ERASURE_EN
    fill_rand(3);
    for (int k = 0; k < 3; k++) er[k][7] = 1;
    send(3, 0);
    chk("t6_pos7", consensus[15:14], 0);
    chk("t6_rel7", reliable[7], 0);
    take(0);
    for (int k = 0; k < 3; k++) er[k][7] = 0;
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
